// File: rtl/stage_compositor.sv
// Two-stage pixel compositor: priority layer/text/fill select, then per-channel
// brightness scaling, plus the stage state machine that drives frame-synchronous fades.
module stage_compositor #(
  parameter int          NUM_LAYERS      = 4,
  parameter logic [23:0] TRANSPARENT_KEY = 24'hFF00FF,
  parameter int          FADE_SHIFT      = 4,
  parameter bit          FADE_EN         = 1'b1
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    pix_valid,
  input  logic [NUM_LAYERS-1:0]   layer_on,
  input  logic [24*NUM_LAYERS-1:0] layer_pixel,
  input  logic [23:0]             bg_pixel,
  input  logic                    text_on,
  input  logic [23:0]             text_rgb,
  input  logic [1:0]              stage_req,
  input  logic                    frame_start,
  output logic [7:0]              VGA_R,
  output logic [7:0]              VGA_G,
  output logic [7:0]              VGA_B,
  output logic                    out_valid,
  output logic [1:0]              stage_cur,
  output logic                    fade_busy
);

  localparam int LW = FADE_SHIFT + 1;
  localparam int PW = 8 + FADE_SHIFT + 1;
  localparam logic [LW-1:0] LMAX = {1'b1, {FADE_SHIFT{1'b0}}};
  localparam logic [LW-1:0] LONE = {{FADE_SHIFT{1'b0}}, 1'b1};

  localparam logic [1:0] ST_START  = 2'd0;
  localparam logic [1:0] ST_BATTLE = 2'd1;
  localparam logic [1:0] ST_WIN    = 2'd2;
  localparam logic [1:0] ST_LOSE   = 2'd3;

  localparam logic [23:0] FILL_START = 24'h000000;
  localparam logic [23:0] FILL_WIN   = 24'h9C1D08;
  localparam logic [23:0] FILL_LOSE  = 24'h57007F;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FADE_OUT = 2'd1,
    S_FADE_IN  = 2'd2
  } fsm_e;

  fsm_e            state_q, state_d;
  logic [1:0]      stage_q, stage_d;
  logic [1:0]      target_q, target_d;
  logic [LW-1:0]   level_q, level_d;
  logic            busy_q, busy_d;

  logic            v1_q, v2_q;
  logic [23:0]     rgb1_q, rgb1_d;
  logic [LW-1:0]   lvl1_q;
  logic [7:0]      r_q, g_q, b_q;

  // Lowest-index covering, non-transparent layer wins; background otherwise.
  function automatic logic [23:0] pick_layer(input logic [NUM_LAYERS-1:0]    on,
                                             input logic [24*NUM_LAYERS-1:0] px,
                                             input logic [23:0]              bg);
    logic [23:0] sel;
    sel = bg;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (on[i] && (px[24*i +: 24] != TRANSPARENT_KEY)) begin
        sel = px[24*i +: 24];
      end else begin
        sel = sel;
      end
    end
    return sel;
  endfunction

  function automatic logic [7:0] fade_ch(input logic [7:0] c, input logic [LW-1:0] l);
    logic [PW-1:0] prod;
    prod = PW'(c) * PW'(l);
    return prod[FADE_SHIFT +: 8];
  endfunction

  // Stage transition next-state logic; only frame_start cycles advance it.
  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    target_d = target_q;
    level_d  = level_q;
    if (frame_start) begin
      case (state_q)
        S_IDLE: begin
          if (stage_req != stage_q) begin
            target_d = stage_req;
            if (FADE_EN) begin
              level_d = LMAX - LONE;
              state_d = S_FADE_OUT;
            end else begin
              stage_d = stage_req;
            end
          end else begin
            target_d = target_q;
          end
        end
        S_FADE_OUT: begin
          level_d = level_q - LONE;
          if (level_q == LONE) begin
            stage_d = target_q;
            state_d = S_FADE_IN;
          end else begin
            state_d = S_FADE_OUT;
          end
        end
        S_FADE_IN: begin
          level_d = level_q + LONE;
          if (level_q == (LMAX - LONE)) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_FADE_IN;
          end
        end
        default: begin
          state_d = S_IDLE;
          level_d = LMAX;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    busy_d = (state_d != S_IDLE);
  end

  // Pixel source select for the currently displayed stage.
  always_comb begin
    rgb1_d = FILL_START;
    case (stage_q)
      ST_BATTLE: rgb1_d = pick_layer(layer_on, layer_pixel, bg_pixel);
      ST_WIN:    rgb1_d = text_on ? text_rgb : FILL_WIN;
      ST_LOSE:   rgb1_d = text_on ? text_rgb : FILL_LOSE;
      default:   rgb1_d = text_on ? text_rgb : FILL_START;
    endcase
  end

  // Stage state machine registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      stage_q  <= ST_START;
      target_q <= ST_START;
      level_q  <= LMAX;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      target_q <= target_d;
      level_q  <= level_d;
      busy_q   <= busy_d;
    end
  end

  // Two-stage pixel pipeline; each pixel keeps the level captured with it.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      v1_q   <= 1'b0;
      rgb1_q <= 24'h000000;
      lvl1_q <= {LW{1'b0}};
      v2_q   <= 1'b0;
      r_q    <= 8'h00;
      g_q    <= 8'h00;
      b_q    <= 8'h00;
    end else begin
      v1_q   <= pix_valid;
      rgb1_q <= rgb1_d;
      lvl1_q <= level_q;
      v2_q   <= v1_q;
      r_q    <= fade_ch(rgb1_q[23:16], lvl1_q);
      g_q    <= fade_ch(rgb1_q[15:8],  lvl1_q);
      b_q    <= fade_ch(rgb1_q[7:0],   lvl1_q);
    end
  end

  assign VGA_R     = r_q;
  assign VGA_G     = g_q;
  assign VGA_B     = b_q;
  assign out_valid = v2_q;
  assign stage_cur = stage_q;
  assign fade_busy = busy_q;

endmodule

// File: tb/tb_stage_compositor.sv
// Bench for stage_compositor: scoreboard of expected pixels, vector table for
// pixel selection, and scripted sequences for fades, reset and the no-fade variant.
module tb_stage_compositor;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        pix_valid = 1'b0;
  logic [3:0]  layer_on = 4'h0;
  logic [95:0] layer_pixel = 96'h0;
  logic [23:0] bg_pixel = 24'h000000;
  logic        text_on = 1'b0;
  logic [23:0] text_rgb = 24'h000000;
  logic [1:0]  stage_req = 2'd0;
  logic        frame_start = 1'b0;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        out_valid, fade_busy;
  logic [1:0]  stage_cur;

  logic        rst_nf = 1'b1;
  logic [1:0]  req_nf = 2'd0;
  logic        fs_nf = 1'b0;
  logic [7:0]  nf_r, nf_g, nf_b;
  logic        nf_valid, nf_busy;
  logic [1:0]  nf_stage;
  logic        nf_busy_seen = 1'b0;

  stage_compositor dut (
    .Clk(clk), .Reset(rst), .pix_valid(pix_valid), .layer_on(layer_on),
    .layer_pixel(layer_pixel), .bg_pixel(bg_pixel), .text_on(text_on),
    .text_rgb(text_rgb), .stage_req(stage_req), .frame_start(frame_start),
    .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b), .out_valid(out_valid),
    .stage_cur(stage_cur), .fade_busy(fade_busy)
  );

  stage_compositor #(.FADE_EN(1'b0)) dut_nf (
    .Clk(clk), .Reset(rst_nf), .pix_valid(pix_valid), .layer_on(layer_on),
    .layer_pixel(layer_pixel), .bg_pixel(bg_pixel), .text_on(text_on),
    .text_rgb(text_rgb), .stage_req(req_nf), .frame_start(fs_nf),
    .VGA_R(nf_r), .VGA_G(nf_g), .VGA_B(nf_b), .out_valid(nf_valid),
    .stage_cur(nf_stage), .fade_busy(nf_busy)
  );

  typedef struct {
    logic [3:0]  lon;
    logic [95:0] lpx;
    logic [23:0] bg;
    logic        ton;
    logic [23:0] trgb;
  } pix_t;

  typedef struct {
    logic [1:0]  stg;
    pix_t        p;
    logic [23:0] exp;
  } tv_t;

  typedef struct {
    int          due;
    logic [23:0] rgb;
  } sb_t;

  sb_t sbq[$];
  tv_t tv[10];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;

  // Reference model of the displayed stage and brightness level.
  int m_state = 0;
  int m_stage = 0;
  int m_level = 16;
  int m_target = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (nf_busy === 1'b1) nf_busy_seen = 1'b1;

  function automatic pix_t mk(input logic [3:0] lon, input logic [23:0] l3, input logic [23:0] l2,
                              input logic [23:0] l1, input logic [23:0] l0, input logic [23:0] bg,
                              input logic ton, input logic [23:0] trgb);
    pix_t p;
    p.lon = lon; p.lpx = {l3, l2, l1, l0}; p.bg = bg; p.ton = ton; p.trgb = trgb;
    return p;
  endfunction

  function automatic logic [7:0] fade8(input logic [7:0] c);
    int x;
    x = (int'(c) * m_level) / 16;
    return x[7:0];
  endfunction

  function automatic logic [23:0] ref_pixel(input pix_t p);
    logic [23:0] s;
    logic [23:0] lp;
    s = 24'h000000;
    if (m_stage == 1) begin
      s = p.bg;
      for (int i = 3; i >= 0; i--) begin
        lp = p.lpx[24*i +: 24];
        if (p.lon[i] && lp != 24'hFF00FF) s = lp;
      end
    end else if (p.ton) s = p.trgb;
    else if (m_stage == 2) s = 24'h9C1D08;
    else if (m_stage == 3) s = 24'h57007F;
    return {fade8(s[23:16]), fade8(s[15:8]), fade8(s[7:0])};
  endfunction

  task automatic model_frame(input logic [1:0] req);
    case (m_state)
      0: if (int'(req) != m_stage) begin m_target = int'(req); m_level = 15; m_state = 1; end
      1: begin m_level--; if (m_level == 0) begin m_stage = m_target; m_state = 2; end end
      default: begin m_level++; if (m_level == 16) m_state = 0; end
    endcase
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock: drive inputs after the edge, record expectation, advance model.
  task automatic step(input pix_t p, input logic v, input logic fs, input logic r,
                      input logic [1:0] req, input logic use_exp, input logic [23:0] exp);
    sb_t e;
    @(posedge clk); #1;
    rst = r; pix_valid = v; frame_start = fs; stage_req = req;
    layer_on = p.lon; layer_pixel = p.lpx; bg_pixel = p.bg; text_on = p.ton; text_rgb = p.trgb;
    if (r) begin
      while (sbq.size() > 0 && sbq[$].due > cyc) e = sbq.pop_back();
      m_state = 0; m_stage = 0; m_level = 16; m_target = 0;
    end else begin
      if (v) begin
        e.due = cyc + 2;
        e.rgb = use_exp ? exp : ref_pixel(p);
        sbq.push_back(e);
      end
      if (fs) model_frame(req);
    end
  endtask

  // Scoreboard: every valid output must match the oldest pending pixel, on time.
  always @(negedge clk) begin
    sb_t e;
    if (out_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk("pix_rgb", {8'h00, vga_r, vga_g, vga_b}, {8'h00, e.rgb});
        chk("pix_latency", cyc, e.due);
      end
    end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      chk("missing_valid", 32'd0, 32'd1);
    end
  end

  initial begin
    pix_t pz, pw, pt, pf;
    logic [1:0] rq;
    pz = mk(4'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 1'b0, 24'h0);
    pw = mk(4'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'hFFFFFF, 1'b0, 24'h0);
    pt = mk(4'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 1'b1, 24'hA5C3E1);
    pf = mk(4'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 1'b0, 24'h0);

    tv[0] = '{2'd0, mk(4'hF, 24'h111111, 24'h222222, 24'h333333, 24'h444444, 24'h555555, 1'b1, 24'hFF0000), 24'hFF0000};
    tv[1] = '{2'd0, mk(4'hF, 24'h111111, 24'h222222, 24'h333333, 24'h444444, 24'h555555, 1'b0, 24'hFF0000), 24'h000000};
    tv[2] = '{2'd0, mk(4'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 1'b1, 24'h0A0B0C), 24'h0A0B0C};
    tv[3] = '{2'd1, mk(4'b0110, 24'h0, 24'h00FF00, 24'hFF00FF, 24'h0, 24'h777777, 1'b0, 24'h0), 24'h00FF00};
    tv[4] = '{2'd1, mk(4'b0000, 24'h0, 24'h00FF00, 24'hFF00FF, 24'h0, 24'h123456, 1'b0, 24'h0), 24'h123456};
    tv[5] = '{2'd1, mk(4'b1111, 24'h445566, 24'h00FF00, 24'hC0FFEE, 24'h112233, 24'h123456, 1'b0, 24'h0), 24'h112233};
    tv[6] = '{2'd1, mk(4'b1000, 24'h445566, 24'h00FF00, 24'hC0FFEE, 24'h112233, 24'h123456, 1'b0, 24'h0), 24'h445566};
    tv[7] = '{2'd1, mk(4'b0001, 24'h0, 24'h0, 24'h0, 24'hFF00FF, 24'hABCDEF, 1'b0, 24'h0), 24'hABCDEF};
    tv[8] = '{2'd1, mk(4'b0011, 24'h0, 24'h0, 24'hC0FFEE, 24'hFF00FF, 24'hABCDEF, 1'b0, 24'h0), 24'hC0FFEE};
    tv[9] = '{2'd1, mk(4'b0000, 24'h0, 24'h0, 24'h0, 24'h0, 24'h123456, 1'b1, 24'hFF0000), 24'h123456};

    // Reset and reset-state checks.
    step(pz, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 24'h0);
    step(pz, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 24'h0);
    step(pz, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 24'h0);
    chk("rst_stage", stage_cur, 32'd0);
    chk("rst_busy", fade_busy, 32'd0);
    chk("rst_rgb", {vga_r, vga_g, vga_b}, 32'd0);
    chk("rst_valid", out_valid, 32'd0);

    // Start-stage selection vectors, with bubbles between pixels.
    for (int i = 0; i < 10; i++) begin
      if (tv[i].stg == 2'd0) begin
        step(tv[i].p, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, tv[i].exp);
        step(pz, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 24'h0);
      end
    end

    // Full start -> battle transition on a white background.
    for (int k = 1; k <= 32; k++) begin
      step(pw, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 24'h0);
      step(pw, 1'b1, 1'b0, 1'b0, 2'd1, (k == 24), 24'h7F7F7F);
      chk("fade_stage", stage_cur, (k >= 16) ? 32'd1 : 32'd0);
      chk("fade_busy", fade_busy, (k < 32) ? 32'd1 : 32'd0);
    end

    // Battle-stage selection vectors, back to back.
    for (int i = 0; i < 10; i++) begin
      if (tv[i].stg == 2'd1) step(tv[i].p, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, tv[i].exp);
    end

    // Request change during fade-out is ignored until IDLE.
    step(pw, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 24'h0);
    step(pw, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 24'h0);
    for (int k = 1; k <= 32; k++) begin
      rq = (k <= 5) ? 2'd1 : 2'd3;
      step(pw, 1'b1, 1'b1, 1'b0, rq, 1'b0, 24'h0);
      step(pw, 1'b1, 1'b0, 1'b0, rq, 1'b0, 24'h0);
    end
    chk("ignore_req_stage", stage_cur, 32'd1);
    chk("ignore_req_busy", fade_busy, 32'd0);
    for (int k = 1; k <= 20; k++) begin
      step(pw, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 24'h0);
      step(pf, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 24'h0);
      if (k == 1) begin
        chk("second_fade_busy", fade_busy, 32'd1);
        chk("second_fade_stage", stage_cur, 32'd1);
      end
      if (k == 16) chk("lose_stage", stage_cur, 32'd3);
    end

    // Reset in the middle of fade-in.
    step(pw, 1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 24'h0);
    step(pt, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 24'hA5C3E1);
    chk("midfade_rst_stage", stage_cur, 32'd0);
    chk("midfade_rst_busy", fade_busy, 32'd0);
    chk("midfade_rst_rgb", {vga_r, vga_g, vga_b}, 32'd0);
    chk("midfade_rst_valid", out_valid, 32'd0);
    step(pz, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 24'h0);

    // No-fade variant: switches at the single frame_start.
    rst_nf = 1'b0;
    req_nf = 2'd2;
    step(pf, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 24'h0);
    step(pf, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 24'h0);
    step(pf, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 24'h0);
    chk("nf_hold_stage", nf_stage, 32'd0);
    fs_nf = 1'b1;
    step(pf, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 24'h0);
    fs_nf = 1'b0;
    chk("nf_stage", nf_stage, 32'd2);
    step(pf, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 24'h0);
    step(pf, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 24'h0);
    step(pz, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 24'h0);
    chk("nf_fill_rgb", {nf_r, nf_g, nf_b}, 32'h9C1D08);
    chk("nf_fill_valid", nf_valid, 32'd1);

    for (int k = 0; k < 4; k++) step(pz, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 24'h0);
    chk("sb_drained", sbq.size(), 32'd0);
    chk("nf_never_busy", nf_busy_seen, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stage_compositor.md
# stage_compositor

Parametrised, pipelined pixel compositor that supersedes the single-purpose colour mapper in the VGA output path. It merges NUM_LAYERS prioritised sprite layers, a text overlay and the background frame-RAM pixel into one RGB value per pixel. It also owns the game-stage display state (start / battle / win / lose), including a frame-synchronous fade-to-black transition between stages. It sits between the sprite/text/background pixel sources and the VGA DAC pins.

## Interface
Parameters:
- NUM_LAYERS, 4: number of sprite layers; layer 0 has the highest priority.
- TRANSPARENT_KEY, 24'hFF00FF: layer pixel value treated as transparent.
- FADE_SHIFT, 4: fade resolution; LMAX = 2^FADE_SHIFT brightness steps.
- FADE_EN, 1: 1 = fade between stages; 0 = switch stages at the next frame_start with no fade.

Ports:
- Clk  in  1  system clock; one clock, all logic on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- pix_valid  in  1  input pixel qualifier.
- layer_on  in  NUM_LAYERS  per-layer coverage of the current pixel.
- layer_pixel  in  24*NUM_LAYERS  packed RGB888; layer i occupies bits [24i+23:24i].
- bg_pixel  in  24  background RGB888.
- text_on  in  1  text glyph bit set for the current pixel.
- text_rgb  in  24  text colour.
- stage_req  in  2  requested stage: 0 start, 1 battle, 2 win, 3 lose.
- frame_start  in  1  one-cycle pulse per frame, asserted only during vertical blank.
- VGA_R, VGA_G, VGA_B  out  8 each  composited and faded colour.
- out_valid  out  1  pix_valid delayed to align with the RGB outputs.
- stage_cur  out  2  stage currently displayed.
- fade_busy  out  1  high while a transition is in progress.

## Operation
Pixel select, pipeline stage 1:
- If stage_cur == battle: the first i (lowest index) with layer_on[i]=1 and layer_pixel[i] != TRANSPARENT_KEY supplies the pixel. If no layer qualifies, bg_pixel is used.
- If stage_cur is start, win or lose: the layer inputs are ignored. If text_on=1, text_rgb is used. Otherwise the stage fill colour is used: start 000000, win 9C1D08, lose 57007F.
- Stage 1 registers the selected RGB together with the current level L.

Fade, pipeline stage 2:
- Each channel out = (c * L) >> FADE_SHIFT.
- The product is 8+FADE_SHIFT+1 bits wide. No rounding is applied.
- L = LMAX returns c exactly. L = 0 gives black.

Transition FSM. States are IDLE, FADE_OUT and FADE_IN. L is FADE_SHIFT+1 bits wide. The FSM advances only on cycles where frame_start=1.
- IDLE: if stage_req != stage_cur, latch target := stage_req.
  - FADE_EN=1: set L := LMAX-1 and go to FADE_OUT.
  - FADE_EN=0: set stage_cur := target and stay in IDLE.
- FADE_OUT: L := L-1. When the decrement reaches 0, set stage_cur := target and go to FADE_IN.
- FADE_IN: L := L+1. When the increment reaches LMAX, go to IDLE.
- stage_req changes during FADE_OUT or FADE_IN are ignored. IDLE re-evaluates stage_req at the first frame_start after returning.
- A request equal to stage_cur causes no action.
- fade_busy = (state != IDLE).

## Timing
- Latency: RGB and out_valid appear exactly 2 cycles after the pix_valid/pixel inputs. There is no back-pressure.
- A new pixel is accepted every cycle.
- Pixels already in the pipeline carry the L value captured at stage 1. A level change never splits a single pixel's channels.
- stage_cur and L update on the clock edge after frame_start.
- A complete transition with FADE_EN=1 takes exactly 2*LMAX frame_starts, counting from the triggering one: LMAX to fade out, LMAX to fade in.
- Reset is synchronous and has priority over all other inputs. Reset mid-fade aborts the transition. Reset values:
  - state = IDLE, stage_cur = 0 (start), L = LMAX, target = 0.
  - VGA_R/G/B = 0, out_valid = 0, fade_busy = 0.
  - Both pipeline stages cleared.
- frame_start in the same cycle as pix_valid is legal. That pixel enters stage 1 with the pre-update L.

## Test plan
- Reset, then hold stage_req=0 with text_on=1, text_rgb=FF0000 and pix_valid=1. Required: RGB = FF,00,00 two cycles later; out_valid follows pix_valid with exactly 2 cycles of delay.
- Set stage_cur=battle with layer_on=4'b0110, layer1=TRANSPARENT_KEY and layer2=00FF00. Required: output 00FF00. Then with layer_on=0 and bg=123456, required: output 123456.
- With FADE_EN=1 and FADE_SHIFT=4, start in start stage and set stage_req=1 with text_on=0. Count frame_starts:
  - stage_cur changes to 1 after the 16th frame_start.
  - fade_busy drops after the 32nd frame_start.
  - With the pixel held at FFFFFF, L=8 gives RGB 7F,7F,7F.
- During FADE_OUT, change stage_req from 1 to 3. Required: the transition completes to stage 1. Stage 3 fade-out begins at the next frame_start after IDLE is reached.
- Assert Reset in the middle of FADE_IN. Required: the next cycle shows stage_cur=0, fade_busy=0 and VGA outputs 0. The first valid pixel after release is at full brightness.
- With FADE_EN=0, set stage_req=2 and pulse frame_start once. Required: stage_cur=2 the next cycle and fill colour 9C1D08 at full brightness, with fade_busy never asserted.
